// File: rtl/dispatcher_pkg.sv
// Shared constants for the destination dispatcher: widths, occupancy encoding, destination slice.
// No logic; imported by dest_dispatcher and dispatch_skid2.
// Backpressure: not applicable.
package dispatcher_pkg;

    localparam int DISP_DATA_W  = 10;
    localparam int DISP_DEST_W  = 2;
    localparam int N_DEST       = 4;
    // Destination field msb sits DEST_MSB_OFS below DATA_W, spanning DEST_W bits downward.
    localparam int DEST_MSB_OFS = 1;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_state_t;

endpackage

// File: rtl/dispatch_skid2.sv
// Two-entry in-order word buffer holding words read from the source FIFO.
// Latency: a written word is visible at head the cycle after wr_en.
// Backpressure: caller must not write when full unless it reads in the same cycle.
module dispatch_skid2 #(
    parameter int DATA_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] head,
    output logic              head_valid,
    output logic [1:0]        count
);

    logic [DATA_W-1:0] mem [2];
    logic              wr_ptr;
    logic              rd_ptr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (rd_en) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, wr_en} - {1'b0, rd_en};
        end
    end

    assign head       = mem[rd_ptr];
    assign head_valid = (count != 2'd0);

endmodule

// File: rtl/dest_dispatcher.sv
// Pops a source FIFO and routes each word, in strict order, to one of four destination FIFOs by its top bits.
// Latency: pop to push is two cycles minimum; one word per cycle sustained. Optional counters: DISPATCH_CNT_EN.
// Backpressure: a head whose destination is almost full stalls every later word; reads stop at occupancy 2.
module dest_dispatcher
    import dispatcher_pkg::*;
#(
    parameter int DATA_W = DISP_DATA_W,
    parameter int DEST_W = DISP_DEST_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              empty_in,
    output logic              pop_in,
    input  logic [DATA_W-1:0] in_data,
    input  logic              almost_full_P0,
    input  logic              almost_full_P1,
    input  logic              almost_full_P2,
    input  logic              almost_full_P3,
    output logic              push_F0,
    output logic              push_F1,
    output logic              push_F2,
    output logic              push_F3,
    output logic [DATA_W-1:0] out_FIFO_0,
    output logic [DATA_W-1:0] out_FIFO_1,
    output logic [DATA_W-1:0] out_FIFO_2,
    output logic [DATA_W-1:0] out_FIFO_3,
    output logic [7:0]        cnt_P0,
    output logic [7:0]        cnt_P1,
    output logic [7:0]        cnt_P2,
    output logic [7:0]        cnt_P3
);

    occ_state_t        state;
    occ_state_t        state_nxt;
    logic              rd_pend;
    logic [1:0]        occ_after;
    logic              wr_en;
    logic [DATA_W-1:0] head;
    logic              head_valid;
    logic [1:0]        buf_count;
    logic [DEST_W-1:0] dest;
    logic [N_DEST-1:0] af_vec;
    logic [N_DEST-1:0] push_vec;
    logic              push_fire;

    // A live entry is never overwritten: a capture into a full buffer needs a retire in the same cycle.
    assign wr_en = rd_pend & ((buf_count != 2'd2) | push_fire);

    dispatch_skid2 #(.DATA_W(DATA_W)) u_skid (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_data    (in_data),
        .rd_en      (push_fire),
        .head       (head),
        .head_valid (head_valid),
        .count      (buf_count)
    );

    assign af_vec = {almost_full_P3, almost_full_P2, almost_full_P1, almost_full_P0};
    assign dest   = head[DATA_W-DEST_MSB_OFS -: DEST_W];

    always_comb begin
        push_vec = '0;
        for (int k = 0; k < N_DEST; k++) begin
            if (head_valid && (dest == DEST_W'(k)) && !af_vec[k]) begin
                push_vec[k] = 1'b1;
            end
        end
    end

    assign push_fire = |push_vec;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= EMPTY;
            rd_pend <= 1'b0;
        end else begin
            state   <= state_nxt;
            rd_pend <= pop_in;
        end
    end

    // Occupancy includes the read in flight, so a new read is issued only if it cannot overflow.
    always_comb begin
        state_nxt = state;
        occ_after = state - 2'(push_fire);
        pop_in    = reset & ~empty_in & (occ_after <= 2'd1);
        case ({pop_in, push_fire})
            2'b10:   state_nxt = (state == EMPTY) ? ONE : TWO;
            2'b01:   state_nxt = (state == TWO) ? ONE : EMPTY;
            default: state_nxt = state;
        endcase
    end

    assign push_F0    = push_vec[0];
    assign push_F1    = push_vec[1];
    assign push_F2    = push_vec[2];
    assign push_F3    = push_vec[3];
    assign out_FIFO_0 = push_vec[0] ? head : '0;
    assign out_FIFO_1 = push_vec[1] ? head : '0;
    assign out_FIFO_2 = push_vec[2] ? head : '0;
    assign out_FIFO_3 = push_vec[3] ? head : '0;

`ifdef DISPATCH_CNT_EN
    logic [7:0] cnt [N_DEST];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < N_DEST; k++) cnt[k] <= '0;
        end else begin
            for (int k = 0; k < N_DEST; k++) begin
                if (push_vec[k]) cnt[k] <= cnt[k] + 8'd1;
            end
        end
    end

    assign cnt_P0 = cnt[0];
    assign cnt_P1 = cnt[1];
    assign cnt_P2 = cnt[2];
    assign cnt_P3 = cnt[3];
`else
    assign cnt_P0 = '0;
    assign cnt_P1 = '0;
    assign cnt_P2 = '0;
    assign cnt_P3 = '0;
`endif

endmodule
